// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Types only: no latency, no backpressure.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      S_WAIT,
      S_FETCH,
      S_SHOW
   } scan_state_t;

   typedef logic [3:0] digit_t;
   typedef logic [5:0] alnum_t;

   localparam int DEFAULT_PRESCALE = 1000;

endpackage

// File: rtl/seven_seg_scan_ctrl_prescaler.sv
// Refresh prescaler: one-cycle tick after PRESCALE enabled cycles, then restarts.
// Latency: tick is combinational on the terminal count; no backpressure (en only gates counting).
module scan_prescaler
   import seven_seg_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(PRESCALE + 1);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit scan over one shared external decoder; SEVEN_SEG_SCAN_BLANK_EN adds leading-zero blanking.
// Slot = PRESCALE + max(DEC_LAT,1) + 1 cycles; no backpressure, loads commit only at frame boundaries.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int DEC_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] load_data,
   output logic                  load_ack,
   output logic [3:0]            dec_value,
   input  logic [5:0]            dec_alnum,
   output logic [5:0]            seg_out,
   output logic [N_DIGITS-1:0]   digit_sel,
   output logic                  frame_done
);

   localparam int IW = $clog2(N_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
   localparam int FETCH_CYC = (DEC_LAT < 1) ? 1 : DEC_LAT;
   localparam logic [1:0] FETCH_LAST = 2'(FETCH_CYC - 1);

   scan_state_t           state, state_nxt;
   logic [IW-1:0]         idx;
   logic [1:0]            fetch_cnt;
   logic [4*N_DIGITS-1:0] shadow;
   logic [4*N_DIGITS-1:0] pend_buf;
   logic                  pending;
   logic                  tick;
   logic                  prescale_en;
   logic                  boundary;
   digit_t                cur_digit;
   logic [N_DIGITS-1:0]   sel_onehot;
   logic [N_DIGITS-1:0]   show_sel;

   assign prescale_en = (state == S_WAIT);

   scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (prescale_en),
      .tick  (tick)
   );

   assign cur_digit  = shadow[int'(idx)*4 +: 4];
   assign sel_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
   assign boundary   = (state == S_SHOW) && (idx == IDX_LAST);
   assign frame_done = boundary;
   assign load_ack   = boundary && (pending || load);

`ifdef SEVEN_SEG_SCAN_BLANK_EN
   // Blank when this digit and every more-significant digit are zero; digit 0 always lit.
   logic lead_zero;
   always_comb begin
      lead_zero = (idx != '0);
      for (int k = 0; k < N_DIGITS; k++) begin
         if (k >= int'(idx) && shadow[4*k +: 4] != 4'd0) begin
            lead_zero = 1'b0;
         end
      end
   end
   assign show_sel = lead_zero ? '0 : sel_onehot;
`else
   assign show_sel = sel_onehot;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (tick) state_nxt = S_FETCH;
         S_FETCH: if (fetch_cnt == FETCH_LAST) state_nxt = S_SHOW;
         S_SHOW:  state_nxt = S_WAIT;
         default: state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         fetch_cnt <= '0;
         dec_value <= '0;
         seg_out   <= '0;
         digit_sel <= '0;
         shadow    <= '0;
         pend_buf  <= '0;
         pending   <= 1'b0;
      end else begin
         case (state)
            S_WAIT: begin
               // Blank the digit lines while the decoder settles on the next value.
               if (tick) begin
                  dec_value <= cur_digit;
                  digit_sel <= '0;
                  fetch_cnt <= '0;
               end
            end
            S_FETCH: begin
               fetch_cnt <= fetch_cnt + 2'd1;
            end
            S_SHOW: begin
               seg_out   <= dec_alnum;
               digit_sel <= show_sel;
               idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            default: ;
         endcase

         // A load in the boundary cycle bypasses the pending buffer.
         if (boundary && (load || pending)) begin
            shadow  <= load ? load_data : pend_buf;
            pending <= 1'b0;
         end else if (load) begin
            pend_buf <= load_data;
            pending  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (N_DIGITS=4, PRESCALE=4, DEC_LAT=1).
// Expectations follow SEVEN_SEG_SCAN_BLANK_EN when it is defined.
module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int DL    = 1;
   localparam int SLOT  = PS + 1 + 1;

`ifdef SEVEN_SEG_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        load      = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_ack;
   logic [3:0]  dec_value;
   logic [5:0]  dec_alnum = '0;
   logic [5:0]  seg_out;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int         slot;
      logic [3:0] dv;
      logic [3:0] sel;
      logic [5:0] seg;
   } slot_exp_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      int          ack_cyc;
      int          frame;
   } load_vec_t;

   slot_exp_t sb[$];
   int        ack_q[$];
   load_vec_t vecs[6];

   seven_seg_scan_ctrl #(
      .N_DIGITS (ND),
      .PRESCALE (PS),
      .DEC_LAT  (DL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_data  (load_data),
      .load_ack   (load_ack),
      .dec_value  (dec_value),
      .dec_alnum  (dec_alnum),
      .seg_out    (seg_out),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] dec_model(input logic [3:0] v);
      return {v[1:0], v} ^ 6'h2A;
   endfunction

   // Decoder stand-in with one cycle of latency.
   always @(posedge clk) dec_alnum <= dec_model(dec_value);

   always @(posedge clk) begin
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_frame(input int frame, input logic [15:0] v);
      for (int k = 0; k < ND; k++) begin
         slot_exp_t   e;
         logic [15:0] upper;
         upper = v >> (4*k);
         e.slot = frame*ND + k;
         e.dv   = v[4*k +: 4];
         e.sel  = (BLANK && k != 0 && upper == 16'h0) ? 4'b0000 : 4'(1 << k);
         e.seg  = dec_model(e.dv);
         sb.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_cyc", cyc, c);
   endtask

   always @(negedge clk) begin : monitor
      int p;
      int s;
      if (reset) begin
         chk("rst_seg_out", seg_out, 0);
         chk("rst_digit_sel", digit_sel, 0);
         chk("rst_dec_value", dec_value, 0);
         chk("rst_load_ack", load_ack, 0);
         chk("rst_frame_done", frame_done, 0);
      end else begin
         p = cyc % SLOT;
         s = cyc / SLOT;
         chk("frame_done", frame_done, (p == SLOT-1) && (s % ND == ND-1));
         if (ack_q.size() > 0 && ack_q[0] == cyc) begin
            chk("load_ack", load_ack, 1);
            void'(ack_q.pop_front());
         end else begin
            chk("load_ack_idle", load_ack, 0);
         end
         if (p == SLOT-2 && sb.size() > 0 && sb[0].slot == s) begin
            chk("dec_value", dec_value, sb[0].dv);
            chk("fetch_blank", digit_sel, 0);
         end
         if (p == 0 && s > 0 && sb.size() > 0 && sb[0].slot == s-1) begin
            chk("digit_sel", digit_sel, sb[0].sel);
            chk("seg_out", seg_out, sb[0].seg);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      // {load cycle, data, expected ack cycle (-1 none), frame shown (-1 none)}
      vecs[0] = '{30,  16'h4321, 47,  2};
      vecs[1] = '{52,  16'hAAAA, -1, -1};
      vecs[2] = '{60,  16'h5555, 71,  3};
      vecs[3] = '{95,  16'h9876, 95,  4};
      vecs[4] = '{100, 16'h0070, 119, 5};
      vecs[5] = '{150, 16'h1111, -1, -1};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      expect_frame(0, 16'h0000);
      expect_frame(1, 16'h0000);

      foreach (vecs[i]) begin
         wait_cyc(vecs[i].cyc);
         load      = 1'b1;
         load_data = vecs[i].data;
         if (vecs[i].ack_cyc >= 0) ack_q.push_back(vecs[i].ack_cyc);
         if (vecs[i].frame >= 0) expect_frame(vecs[i].frame, vecs[i].data);
         @(posedge clk);
         #1 load = 1'b0;
      end

      // Reset during the FETCH of idx 2 while 16'h1111 is still pending.
      wait_cyc(160);
      chk("pre_rst_seg_out", seg_out, dec_model(4'd7));
      reset = 1'b1;
      #1;
      chk("midrst_seg_out", seg_out, 0);
      chk("midrst_digit_sel", digit_sel, 0);
      chk("midrst_load_ack", load_ack, 0);
      chk("sb_drained", sb.size(), 0);
      chk("ack_drained", ack_q.size(), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      expect_frame(0, 16'h0000);
      expect_frame(1, 16'h0000);
      wait_cyc(55);
      chk("sb_final", sb.size(), 0);
      chk("ack_final", ack_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
